vga_sync_gen: RTL and testbench
===============================

// Module: vga_sync_gen
// PURPOSE
//  VGA timing generator: produces the pixel position (x, y), activeVideo, hsync and
//  vsync consumed by the pixel-drawing stage and the VGA connector.
//  Divides the system clock into a pixel tick and runs horizontal/vertical counters
//  through ACTIVE/FRONT/SYNC/BACK phases. Default timing: 640x480@60 from 50 MHz.
// PARAMETERS
//  CLK_DIV   2    system clocks per pixel (>=1)
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch, pixels
//  H_SYNC    96   hsync pulse width, pixels
//  H_BP      48   horizontal back porch, pixels
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch, lines
//  V_SYNC    2    vsync pulse width, lines
//  V_BP      33   vertical back porch, lines
//  HS_POL    0    hsync active level (0 = active-low)
//  VS_POL    0    vsync active level (0 = active-low)
// PORTS
//  clk          in   1   system clock; all logic on posedge
//  rst          in   1   asynchronous, active-low reset
//  pix_en       out  1   one-clk pulse on each pixel update (every CLK_DIV clks)
//  x            out  10  horizontal counter value, 0..H_TOTAL-1
//  y            out  10  vertical counter value, 0..V_TOTAL-1
//  activeVideo  out  1   1 when x<H_ACTIVE and y<V_ACTIVE
//  hsync        out  1   horizontal sync, level per HS_POL
//  vsync        out  1   vertical sync, level per VS_POL
//  line_start   out  1   one-clk pulse when x becomes 0
//  frame_start  out  1   one-clk pulse when x and y both become 0
// BEHAVIOUR
//  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525); both <=1024.
//  - Reset (rst=0, async): div=0, h_cnt=0, v_cnt=0; x=0, y=0, activeVideo=0,
//    pix_en=0, line_start=0, frame_start=0, hsync=~HS_POL, vsync=~VS_POL.
//  - Divider: div counts 0..CLK_DIV-1 and wraps; internal tick = (div==CLK_DIV-1).
//    CLK_DIV=1 gives tick every clk.
//  - On a tick edge: all outputs register the CURRENT (h_cnt, v_cnt); then h_cnt
//    advances. h_cnt wraps H_TOTAL-1 -> 0 and increments v_cnt on the same edge;
//    v_cnt wraps V_TOTAL-1 -> 0. Outputs hold between ticks.
//  - pix_en, line_start and frame_start are 1 for exactly the clk after a tick edge,
//    0 otherwise. line_start when registered h_cnt==0; frame_start when h_cnt==0
//    and v_cnt==0.
//  - First tick after reset release presents x=0, y=0, activeVideo=1, line_start=1,
//    frame_start=1 (CLK_DIV=2: on the 2nd posedge after release).
//  - H phase FSM (tracks h_cnt): H_ACT [0,H_ACTIVE) -> H_FRONT -> H_SYNC
//    [H_ACTIVE+H_FP, +H_SYNC) -> H_BACK -> H_ACT on wrap. V phase FSM is identical
//    on v_cnt, advancing only on h wrap.
//  - hsync = HS_POL while in H_SYNC, else ~HS_POL. vsync = VS_POL while in V_SYNC,
//    else ~VS_POL; vsync changes only together with x becoming 0.
//  - activeVideo = (H_ACT && V_ACT), registered with x/y (no extra latency vs x, y).
//  - Reset asserted mid-frame: all state returns to reset values immediately; on
//    release timing restarts from (0,0). No partial frames are resumed.
//  - Counters are 10-bit unsigned; no value >=H_TOTAL / >=V_TOTAL is ever output.
// TESTING
//  1 Hold rst=0 10 clks -> all outputs at reset values; hsync=vsync=1 (default pol).
//  2 Release rst -> 2nd posedge: pix_en=1, x=0, y=0, activeVideo=1, frame_start=1;
//    pix_en period = 2 clks thereafter.
//  3 Line: x walks 0..799 then 0; activeVideo falls at x=640; hsync=0 for x=656..751
//    (192 clks); line_start period = 1600 clks.
//  4 Frame: vsync=0 for y=490..491 only; frame_start period = 840000 clks;
//    activeVideo high for exactly 307200 pix_en cycles per frame.
//  5 Assert rst at x=300,y=200 for 3 clks, release -> outputs reset at once; restart
//    at (0,0) with frame_start=1 on the 2nd posedge.
//  6 CLK_DIV=1, HS_POL=VS_POL=1 -> pix_en constantly 1; hsync=1 for x=656..751;
//    line period 800 clks.

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-tick divider, horizontal/vertical counters with
// phase FSMs, and registered position/sync/strobe outputs.
module vga_sync_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       activeVideo,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start
);

  // state    | meaning
  // PH_ACT   | counter inside the visible region
  // PH_FRONT | front porch
  // PH_SYNC  | sync pulse asserted
  // PH_BACK  | back porch, wraps to PH_ACT
  typedef enum logic [1:0] {PH_ACT, PH_FRONT, PH_SYNC, PH_BACK} phase_t;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE - 1);
  localparam logic [9:0] H_FP_END   = 10'(H_ACTIVE + H_FP - 1);
  localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE - 1);
  localparam logic [9:0] V_FP_END   = 10'(V_ACTIVE + V_FP - 1);
  localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;
  logic [9:0]    h_cnt, v_cnt;
  logic          tick, h_wrap, v_wrap;
  phase_t        h_state, h_state_nxt, v_state, v_state_nxt;

  assign tick   = (div == DIV_LAST);
  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div     <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
      h_state <= PH_ACT;
      v_state <= PH_ACT;
    end else begin
      div     <= tick ? '0 : div + 1'b1;
      h_state <= h_state_nxt;
      v_state <= v_state_nxt;
      if (tick) begin
        h_cnt <= h_wrap ? '0 : h_cnt + 10'd1;
        if (h_wrap) v_cnt <= v_wrap ? '0 : v_cnt + 10'd1;
      end
    end
  end

  always_comb begin
    h_state_nxt = h_state;
    v_state_nxt = v_state;
    if (tick) begin
      case (h_state)
        PH_ACT:   if (h_cnt == H_ACT_END)  h_state_nxt = PH_FRONT;
        PH_FRONT: if (h_cnt == H_FP_END)   h_state_nxt = PH_SYNC;
        PH_SYNC:  if (h_cnt == H_SYNC_END) h_state_nxt = PH_BACK;
        PH_BACK:  if (h_wrap)              h_state_nxt = PH_ACT;
        default:                           h_state_nxt = PH_ACT;
      endcase
      // vertical phase only moves on the horizontal wrap
      if (h_wrap) begin
        case (v_state)
          PH_ACT:   if (v_cnt == V_ACT_END)  v_state_nxt = PH_FRONT;
          PH_FRONT: if (v_cnt == V_FP_END)   v_state_nxt = PH_SYNC;
          PH_SYNC:  if (v_cnt == V_SYNC_END) v_state_nxt = PH_BACK;
          PH_BACK:  if (v_wrap)              v_state_nxt = PH_ACT;
          default:                           v_state_nxt = PH_ACT;
        endcase
      end
    end
  end

  // Outputs capture the pre-advance counters so x/y/sync/active stay aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_en      <= 1'b0;
      x           <= '0;
      y           <= '0;
      activeVideo <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (tick) begin
      pix_en      <= 1'b1;
      x           <= h_cnt;
      y           <= v_cnt;
      activeVideo <= (h_state == PH_ACT) && (v_state == PH_ACT);
      hsync       <= (h_state == PH_SYNC) ? HS_POL : ~HS_POL;
      vsync       <= (v_state == PH_SYNC) ? VS_POL : ~VS_POL;
      line_start  <= (h_cnt == 10'd0);
      frame_start <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
    end else begin
      pix_en      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: default timing, a shrunken frame for full-frame
// and reset checks, and a CLK_DIV=1 positive-polarity variant.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  logic       d_pe, d_av, d_hs, d_vs, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  logic       s_pe, s_av, s_hs, s_vs, s_ls, s_fs;
  logic [9:0] s_x, s_y;
  logic       p_pe, p_av, p_hs, p_vs, p_ls, p_fs;
  logic [9:0] p_x, p_y;

  vga_sync_gen dut_d (
    .clk(clk), .rst(rst), .pix_en(d_pe), .x(d_x), .y(d_y), .activeVideo(d_av),
    .hsync(d_hs), .vsync(d_vs), .line_start(d_ls), .frame_start(d_fs));

  vga_sync_gen #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_s (
    .clk(clk), .rst(rst), .pix_en(s_pe), .x(s_x), .y(s_y), .activeVideo(s_av),
    .hsync(s_hs), .vsync(s_vs), .line_start(s_ls), .frame_start(s_fs));

  vga_sync_gen #(.CLK_DIV(1), .HS_POL(1'b1), .VS_POL(1'b1)) dut_p (
    .clk(clk), .rst(rst), .pix_en(p_pe), .x(p_x), .y(p_y), .activeVideo(p_av),
    .hsync(p_hs), .vsync(p_vs), .line_start(p_ls), .frame_start(p_fs));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected outputs k posedges after reset release, from the pixel index alone.
  task automatic model_chk(input string nm, input int k, input int dv,
                           input int ha, input int hf, input int hsw, input int hb,
                           input int va, input int vf, input int vsw, input int vb,
                           input logic pol, input logic pe, input logic [9:0] xo,
                           input logic [9:0] yo, input logic av, input logic hso,
                           input logic vso, input logic ls, input logic fs);
    int p, ht, vt, ex, ey;
    logic epe, eav, ehs, evs, els, efs;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    p  = k / dv - 1;
    if (p < 0) begin
      ex = 0; ey = 0; epe = 1'b0; eav = 1'b0;
      ehs = ~pol; evs = ~pol; els = 1'b0; efs = 1'b0;
    end else begin
      ex  = p % ht;
      ey  = (p / ht) % vt;
      epe = (k % dv) == 0;
      eav = (ex < ha) && (ey < va);
      ehs = (ex >= ha + hf && ex < ha + hf + hsw) ? pol : ~pol;
      evs = (ey >= va + vf && ey < va + vf + vsw) ? pol : ~pol;
      els = epe && (ex == 0);
      efs = els && (ey == 0);
    end
    chk({nm, ".pix_en"}, 32'(pe), 32'(epe));
    chk({nm, ".x"}, 32'(xo), ex);
    chk({nm, ".y"}, 32'(yo), ey);
    chk({nm, ".active"}, 32'(av), 32'(eav));
    chk({nm, ".hsync"}, 32'(hso), 32'(ehs));
    chk({nm, ".vsync"}, 32'(vso), 32'(evs));
    chk({nm, ".line_start"}, 32'(ls), 32'(els));
    chk({nm, ".frame_start"}, 32'(fs), 32'(efs));
  endtask

  task automatic check_all(input int k);
    model_chk("def", k, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0,
              d_pe, d_x, d_y, d_av, d_hs, d_vs, d_ls, d_fs);
    model_chk("small", k, 2, 8, 2, 3, 2, 4, 1, 2, 1, 1'b0,
              s_pe, s_x, s_y, s_av, s_hs, s_vs, s_ls, s_fs);
    model_chk("div1", k, 1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1,
              p_pe, p_x, p_y, p_av, p_hs, p_vs, p_ls, p_fs);
  endtask

  initial begin
    int cnt_d, cnt_s, cnt_p;
    bit found;

    // reset held for 10 clocks
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_all(0);
    chk("rst.def.hsync", 32'(d_hs), 32'd1);
    chk("rst.def.vsync", 32'(d_vs), 32'd1);
    chk("rst.div1.hsync", 32'(p_hs), 32'd0);

    // release and run several small frames / two default lines
    rst = 1'b1;
    cnt_d = 0; cnt_s = 0; cnt_p = 0;
    for (int k = 1; k <= 3400; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_all(k);
      if (k == 2) begin
        chk("first.def.x", 32'(d_x), 32'd0);
        chk("first.def.active", 32'(d_av), 32'd1);
        chk("first.def.frame_start", 32'(d_fs), 32'd1);
      end
      if (k <= 1600 && d_pe && d_av) cnt_d++;
      if (k <= 240 && s_pe && s_av) cnt_s++;
      if (k <= 800 && p_pe && p_av) cnt_p++;
    end
    chk("count.def.active_line", cnt_d, 640);
    chk("count.small.active_frame", cnt_s, 32);
    chk("count.div1.active_line", cnt_p, 640);

    // mid-frame reset on the small instance at x=5,y=2
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      if (s_x == 10'd5 && s_y == 10'd2) found = 1'b1;
    end
    chk("wait.small.mid_frame", 32'(found), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("async.small.x", 32'(s_x), 32'd0);
    chk("async.small.y", 32'(s_y), 32'd0);
    chk("async.small.active", 32'(s_av), 32'd0);
    chk("async.small.hsync", 32'(s_hs), 32'd1);
    chk("async.def.x", 32'(d_x), 32'd0);
    chk("async.div1.pix_en", 32'(p_pe), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all(0);
    rst = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_all(k);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
